tia_phase_ctl: RTL and testbench



---
 rtl/tia_phase_pkg.sv | 30 +++
 rtl/tia_phase_hcount.sv | 56 +++++
 rtl/tia_phase_ctl.sv | 91 +++++++++
 tb/tb_tia_phase_ctl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tia_phase_pkg.sv
// Shared constants for the TIA two-phase clock sequencer: one-hot phase state
// indices, counter width/default terminal value, and small state helpers.
package tia_phase_pkg;

   localparam int PHASE_CLKS     = 4;
   localparam int HCOUNT_W       = 6;
   localparam int HCOUNT_MAX_DEF = 56;
   localparam int HCOUNT_MAX_LIM = (1 << HCOUNT_W) - 1;

   // Bit positions inside the one-hot phase register.
   localparam int ST_G2 = 0;
   localparam int ST_P1 = 1;
   localparam int ST_G1 = 2;
   localparam int ST_P2 = 3;

   typedef logic [PHASE_CLKS-1:0] phase_t;

   function automatic phase_t ph_bit(input int idx);
      phase_t v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   localparam phase_t PH_G2 = ph_bit(ST_G2);
   localparam phase_t PH_P1 = ph_bit(ST_P1);
   localparam phase_t PH_G1 = ph_bit(ST_G1);
   localparam phase_t PH_P2 = ph_bit(ST_P2);

endpackage

// File: rtl/tia_phase_hcount.sv
// Horizontal phase counter: counts completed phase cycles, wraps at HCOUNT_MAX.
// Registered outputs; hwrap is a single-clk pulse on the wrapping increment.
module tia_phase_hcount
   import tia_phase_pkg::*;
#(
   parameter int HCOUNT_MAX = HCOUNT_MAX_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                inc,
   input  logic                clr,
   output logic [HCOUNT_W-1:0] hcount,
   output logic                hwrap
);

   localparam logic [HCOUNT_W-1:0] MAX_V = HCOUNT_W'(HCOUNT_MAX);

   generate
      if (HCOUNT_MAX > HCOUNT_MAX_LIM || HCOUNT_MAX < 0) begin : g_bad_max
         $error("tia_phase_hcount: HCOUNT_MAX out of range");
      end
   endgenerate

   logic [HCOUNT_W-1:0] hcount_d, hcount_q;
   logic                hwrap_d, hwrap_q;

   // clr wins over inc so a restart never produces a wrap pulse.
   always_comb begin
      hcount_d = hcount_q;
      hwrap_d  = 1'b0;
      if (clr) begin
         hcount_d = '0;
      end else if (inc) begin
         if (hcount_q == MAX_V) begin
            hcount_d = '0;
            hwrap_d  = 1'b1;
         end else begin
            hcount_d = hcount_q + HCOUNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q <= '0;
         hwrap_q  <= 1'b0;
      end else begin
         hcount_q <= hcount_d;
         hwrap_q  <= hwrap_d;
      end
   end

   assign hcount = hcount_q;
   assign hwrap  = hwrap_q;

endmodule

// File: rtl/tia_phase_ctl.sv
// Two-phase non-overlapping s1/s2 sequencer (color clock / 4) with hold and resync.
// Optional horizontal counter built only when TIA_PHASE_CTL_HCOUNT_EN is defined.
module tia_phase_ctl
   import tia_phase_pkg::*;
#(
   parameter int HCOUNT_MAX = HCOUNT_MAX_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rsync,
   input  logic                hold_req,
   output logic                s1,
   output logic                s2,
   output logic                hold_ack,
   output logic [HCOUNT_W-1:0] hcount,
   output logic                hwrap
);

   generate
      if (HCOUNT_MAX > HCOUNT_MAX_LIM || HCOUNT_MAX < 0) begin : g_bad_max
         $error("tia_phase_ctl: HCOUNT_MAX must fit in 6 bits");
      end
   endgenerate

   phase_t state_d, state_q;
   logic   hold_ack_d, hold_ack_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PH_G2;
         hold_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_ack_q <= hold_ack_d;
      end
   end

   // hold_ack mirrors "next state is G2 and hold requested", so it asserts on
   // the G2 entry edge when hold_req is already up during P2.
   always_comb begin
      state_d    = PH_G2;
      hold_ack_d = 1'b0;
      if (rsync) begin
         state_d = PH_G2;
      end else if (!$onehot(state_q)) begin
         state_d = PH_G2;
      end else if (state_q[ST_G2]) begin
         if (hold_req) begin
            state_d    = PH_G2;
            hold_ack_d = 1'b1;
         end else begin
            state_d = PH_P1;
         end
      end else if (state_q[ST_P1]) begin
         state_d = PH_G1;
      end else if (state_q[ST_G1]) begin
         state_d = PH_P2;
      end else begin
         state_d    = PH_G2;
         hold_ack_d = hold_req;
      end
   end

   // Strobes are raw state flop bits: no decode, so no glitch or overlap.
   always_comb begin
      s1       = state_q[ST_P1];
      s2       = state_q[ST_P2];
      hold_ack = hold_ack_q;
   end

`ifdef TIA_PHASE_CTL_HCOUNT_EN
   logic hc_inc;

   assign hc_inc = (state_q == PH_P2) && !rsync;

   tia_phase_hcount #(
      .HCOUNT_MAX (HCOUNT_MAX)
   ) u_hcount (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (hc_inc),
      .clr    (rsync),
      .hcount (hcount),
      .hwrap  (hwrap)
   );
`else
   assign hcount = '0;
   assign hwrap  = 1'b0;
`endif

endmodule

// File: tb/tb_tia_phase_ctl.sv
// Scoreboarded random bench for tia_phase_ctl against a cycle-position model.
module tb_tia_phase_ctl;
   import tia_phase_pkg::*;

   localparam int HMAX = 56;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       rsync = 1'b0;
   logic       hold_req = 1'b0;
   logic       s1, s2, hold_ack, hwrap;
   logic [5:0] hcount;

   always #5 clk = ~clk;

   tia_phase_ctl #(.HCOUNT_MAX(HMAX)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rsync    (rsync),
      .hold_req (hold_req),
      .s1       (s1),
      .s2       (s2),
      .hold_ack (hold_ack),
      .hcount   (hcount),
      .hwrap    (hwrap)
   );

   typedef struct {
      logic s1;
      logic s2;
      logic ack;
      int   hc;
      logic wrap;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Model: position within the 4-clk cycle (0=gap before s1, 1=s1, 2=gap, 3=s2).
   int   m_pos = 0;
   int   m_cnt = 0;
   logic m_ack = 1'b0;
   logic m_wrap = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos  = 0;
      m_cnt  = 0;
      m_ack  = 1'b0;
      m_wrap = 1'b0;
   endtask

   task automatic model_step(input logic rs, input logic hr);
      exp_t e;
      if (rs) begin
         model_reset();
      end else begin
         m_wrap = 1'b0;
         if (!(m_pos == 0 && hr)) begin
            m_pos = (m_pos + 1) % PHASE_CLKS;
            if (m_pos == 0) begin
`ifdef TIA_PHASE_CTL_HCOUNT_EN
               if (m_cnt == HMAX) begin
                  m_cnt  = 0;
                  m_wrap = 1'b1;
               end else begin
                  m_cnt = m_cnt + 1;
               end
`endif
            end
         end
         m_ack = (m_pos == 0) && hr;
      end
      e.s1   = (m_pos == 1);
      e.s2   = (m_pos == 3);
      e.ack  = m_ack;
      e.hc   = m_cnt;
      e.wrap = m_wrap;
      sb_q.push_back(e);
   endtask

   task automatic cyc(input logic rs, input logic hr);
      @(negedge clk);
      rsync    = rs;
      hold_req = hr;
      model_step(rs, hr);
   endtask

   task automatic release_rst();
      rst_n    = 1'b1;
      rsync    = 1'b0;
      hold_req = 1'b0;
      model_reset();
      model_step(1'b0, 1'b0);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_s1"}, int'(s1), 0);
      chk({tag, "_s2"}, int'(s2), 0);
      chk({tag, "_ack"}, int'(hold_ack), 0);
      chk({tag, "_hcount"}, int'(hcount), 0);
      chk({tag, "_hwrap"}, int'(hwrap), 0);
   endtask

   // Monitor: one scoreboard entry per posedge, sampled 1 time unit later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("s1", int'(s1), int'(e.s1));
            chk("s2", int'(s2), int'(e.s2));
            chk("hold_ack", int'(hold_ack), int'(e.ack));
            chk("hcount", int'(hcount), e.hc);
            chk("hwrap", int'(hwrap), int'(e.wrap));
            chk("no_overlap", int'(s1 & s2), 0);
         end
      end
   end

   initial begin
      logic hr;
      #1 rst_n = 1'b0;
      #11;
      chk_reset_outs("reset");
      @(negedge clk);
      release_rst();

      repeat (16) cyc(1'b0, 1'b0);

      // Full line from a clean restart: covers every count and one wrap.
      cyc(1'b1, 1'b0);
      repeat (240) cyc(1'b0, 1'b0);

      // Hold raised in P1, kept for a while, then dropped.
      for (int i = 0; i < 8 && m_pos != 1; i++) cyc(1'b0, 1'b0);
      for (int i = 0; i < 8 && !m_ack; i++) cyc(1'b0, 1'b1);
      repeat (10) cyc(1'b0, 1'b1);
      repeat (4) cyc(1'b0, 1'b0);

      // Restart while in P2 part-way through a line.
      for (int i = 0; i < 300 && !(m_pos == 3 && m_cnt >= 30); i++) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      repeat (4) cyc(1'b0, 1'b0);

      // Restart and hold requested together.
      cyc(1'b1, 1'b1);
      repeat (3) cyc(1'b0, 1'b1);
      repeat (3) cyc(1'b0, 1'b0);

      // Short async reset pulse while s1 is high.
      for (int i = 0; i < 8 && m_pos != 1; i++) cyc(1'b0, 1'b0);
      @(posedge clk);
      #2;
      chk("pre_rst_s1", int'(s1), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("async_rst");
      @(negedge clk);
      release_rst();
      repeat (8) cyc(1'b0, 1'b0);

      hr = 1'b0;
      repeat (3000) begin
         if ($urandom_range(0, 7) == 0) hr = ~hr;
         cyc(($urandom_range(0, 63) == 0), hr);
      end

      repeat (3) @(negedge clk);
      chk("sb_drain", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
